// File: rtl/codificador_param.sv
// Registered WIDTH-bit coder: captures data on the rising edge of ready and
// issues a binary, Gray or excess-3 code with parity, valid strobe and error flag.
module codificador_param #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [1:0]           mode,
  input  logic                 ready,
  input  logic                 clear,
  output logic [WIDTH-1:0]     code_out,
  output logic                 parity,
  output logic                 valid,
  output logic                 err,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] count
);

  typedef enum logic [1:0] {IDLE, ENCODE, HOLD} state_t;

  state_t           state_reg, state_next;
  logic             ready_q;
  logic             rise;
  logic [WIDTH-1:0] data_reg;
  logic [1:0]       mode_reg;
  logic [WIDTH-1:0] gray_code;
  logic [WIDTH:0]   xs3_sum;
  logic [WIDTH-1:0] code_next;
  logic             err_next;

  assign rise = ready & ~ready_q;
  assign busy = (state_reg != IDLE);

  // Each Gray bit is the XOR of a data bit with its upper neighbour.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
      assign gray_code[gi] = data_reg[gi] ^ data_reg[gi+1];
    end
  endgenerate
  assign gray_code[WIDTH-1] = data_reg[WIDTH-1];

  assign xs3_sum = {1'b0, data_reg} + {{(WIDTH-1){1'b0}}, 2'b11};

  always_comb begin
    code_next = '0;
    err_next  = 1'b0;
    case (mode_reg)
      2'd0: code_next = data_reg;
      2'd1: code_next = gray_code;
      2'd2: begin
        code_next = xs3_sum[WIDTH-1:0];
        err_next  = xs3_sum[WIDTH];
      end
      default: err_next = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (rise) state_next = ENCODE;
      ENCODE:  state_next = HOLD;
      HOLD:    if (!ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      ready_q   <= 1'b0;
      data_reg  <= '0;
      mode_reg  <= 2'd0;
      code_out  <= '0;
      parity    <= 1'b0;
      err       <= 1'b0;
      valid     <= 1'b0;
      count     <= '0;
    end else begin
      state_reg <= state_next;
      ready_q   <= ready;
      valid     <= (state_reg == ENCODE);
      if (state_reg == IDLE && rise) begin
        data_reg <= data_in;
        mode_reg <= mode;
      end
      if (state_reg == ENCODE) begin
        code_out <= code_next;
        parity   <= ^code_next;
        err      <= err_next;
      end
      // A clear coincident with ENCODE takes priority over the increment.
      if (clear)
        count <= '0;
      else if (state_reg == ENCODE)
        count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_codificador_param.sv
// Scoreboard bench for codificador_param (WIDTH=4): expected codes are queued at
// stimulus time and compared whenever valid is seen.
module tb_codificador_param;

  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  data_in;
  logic [1:0]    mode;
  logic          ready;
  logic          clear;
  logic [W-1:0]  code_out;
  logic          parity;
  logic          valid;
  logic          err;
  logic          busy;
  logic [CW-1:0] count;

  codificador_param #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .mode(mode), .ready(ready),
    .clear(clear), .code_out(code_out), .parity(parity), .valid(valid),
    .err(err), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  data;
    logic [1:0]    md;
    logic [W-1:0]  code;
    logic          par;
    logic          er;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            valid_seen = 0;
  logic [CW-1:0] exp_count = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference encoder written from the mode definitions.
  function automatic exp_t model(input logic [W-1:0] d, input logic [1:0] m, input logic [CW-1:0] c);
    exp_t e;
    int   s;
    e.data = d;
    e.md   = m;
    e.cnt  = c;
    e.er   = 1'b0;
    case (m)
      2'd0: e.code = d;
      2'd1: e.code = d ^ (d >> 1);
      2'd2: begin
        s      = int'(d) + 3;
        e.code = W'(s % (1 << W));
        e.er   = (s >= (1 << W));
      end
      default: begin
        e.code = '0;
        e.er   = 1'b1;
      end
    endcase
    e.par = ^e.code;
    return e;
  endfunction

  always @(negedge clk) begin
    if (valid) begin
      valid_seen++;
      if (sb.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn data=%b mode=%0d code=%b parity=%b err=%b count=%0d",
                 e.data, e.md, code_out, parity, err, count);
        check("code_out", 32'(code_out), 32'(e.code));
        check("parity", 32'(parity), 32'(e.par));
        check("err", 32'(err), 32'(e.er));
        check("count", 32'(count), 32'(e.cnt));
      end
    end
  end

  // One capture at the fastest rate: ready high for E0/E1, low at E2.
  task automatic send(input logic [W-1:0] d, input logic [1:0] m, input bit clr);
    data_in = d;
    mode    = m;
    ready   = 1'b1;
    exp_count = clr ? '0 : exp_count + 1'b1;
    sb.push_back(model(d, m, exp_count));
    @(negedge clk);                       // after E0: ENCODE
    check("busy_e0", 32'(busy), 32'd1);
    check("valid_e0", 32'(valid), 32'd0);
    data_in = W'($urandom);
    mode    = 2'($urandom);
    if (clr) clear = 1'b1;
    @(negedge clk);                       // after E1: HOLD, valid
    clear = 1'b0;
    check("valid_e1", 32'(valid), 32'd1);
    ready = 1'b0;
    @(negedge clk);                       // after E2: back in IDLE
    check("valid_e2", 32'(valid), 32'd0);
    check("busy_e2", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int v0;
    reset   = 1'b0;
    ready   = 1'b0;
    clear   = 1'b0;
    data_in = '0;
    mode    = 2'd0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_code", 32'(code_out), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_par_err", 32'({parity, err}), 32'd0);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    send(4'b1011, 2'd0, 1'b0);

    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    exp_count = '0;
    check("clear_idle", 32'(count), 32'd0);

    for (int d = 0; d < 16; d++) send(W'(d), 2'd1, 1'b0);
    check("sweep_count", 32'(count), 32'd16);

    send(4'd9, 2'd2, 1'b0);
    send(4'd13, 2'd2, 1'b0);
    send(4'd12, 2'd2, 1'b0);
    send(4'd5, 2'd3, 1'b0);
    send(4'd10, 2'd3, 1'b0);

    // ready held high: exactly one capture
    v0 = valid_seen;
    data_in = 4'b0110;
    mode    = 2'd1;
    ready   = 1'b1;
    exp_count = exp_count + 1'b1;
    sb.push_back(model(4'b0110, 2'd1, exp_count));
    repeat (10) @(negedge clk);
    check("held_valids", 32'(valid_seen - v0), 32'd1);
    check("held_busy", 32'(busy), 32'd1);
    ready = 1'b0;
    @(negedge clk);
    check("held_exit", 32'(busy), 32'd0);
    send(4'b0111, 2'd0, 1'b0);

    // clear coincident with ENCODE wins
    send(4'd3, 2'd2, 1'b1);
    send(4'd15, 2'd1, 1'b0);

    // reset during ENCODE discards the pending code
    v0 = valid_seen;
    data_in = 4'd7;
    mode    = 2'd0;
    ready   = 1'b1;
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("arst_code", 32'(code_out), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check("arst_no_valid", 32'(valid_seen - v0), 32'd0);

    // release with ready already high: first edge captures
    data_in = 4'b1001;
    mode    = 2'd1;
    exp_count = 8'd1;
    sb.push_back(model(4'b1001, 2'd1, exp_count));
    reset = 1'b1;
    @(negedge clk);
    check("rel_busy", 32'(busy), 32'd1);
    check("rel_valid0", 32'(valid), 32'd0);
    @(negedge clk);
    check("rel_valid1", 32'(valid), 32'd1);
    ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rel_busy_end", 32'(busy), 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
